counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 SHALL have the ports listed in REQ-002 to REQ-019, in this order; there are no parameters; one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cfg_valid  input  1  configuration offer.
REQ-005 cfg_ready  output  1  high only in IDLE; transfer when cfg_valid&cfg_ready at a rising edge.
REQ-006 cfg_start  input  4  counter reload value.
REQ-007 cfg_last  input  4  terminal count value.
REQ-008 cfg_epochs  input  4  wraps before done; 0 = run until stop.
REQ-009 stop  input  1  abort request.
REQ-010 pause  input  1  hold request; functional only under CTRL_PAUSE_EN.
REQ-011 cnt_q  input  4  counter output from the external 74161-style counter.
REQ-012 cnt_clr_n  output  1  counter clear, active-low.
REQ-013 cnt_ld_n  output  1  counter synchronous load, active-low.
REQ-014 cnt_p  output  1  counter enable P.
REQ-015 cnt_t  output  1  counter enable T.
REQ-016 cnt_d  output  4  counter load data.
REQ-017 busy  output  1  high in LOAD, RUN and DONE.
REQ-018 wrap  output  1  one-cycle pulse per reload at terminal count.
REQ-019 done  output  1  one-cycle pulse on programmed completion; epoch  output  4  completed-wrap count.

Function
REQ-020 States: IDLE, LOAD, RUN, DONE, ABORT; state, config latches, epoch, wrap and done are registered.
REQ-021 cnt_* outputs are combinational from state, latched config and cnt_q.
REQ-022 IDLE: cnt_clr_n=1, cnt_ld_n=1, cnt_p=cnt_t=0, cnt_d=0.
REQ-023 IDLE, on transfer: latch start_r, last_r, epochs_r; clear epoch; go to LOAD.
REQ-024 LOAD lasts one cycle: cnt_ld_n=0, cnt_d=start_r; then RUN.
REQ-025 Counter shows start_r on the second edge after the transfer.
REQ-026 RUN, cnt_q!=last_r: cnt_p=cnt_t=1, cnt_ld_n=1.
REQ-027 RUN, cnt_q==last_r: cnt_ld_n=0, cnt_d=start_r, and epoch increments mod 16.
REQ-028 Same cycle as REQ-027: wrap=1 in the next cycle.
REQ-029 Same cycle as REQ-027, if epochs_r!=0 and epoch+1==epochs_r: go to DONE instead of staying in RUN.
REQ-030 start_r==last_r: reload and wrap every RUN cycle.
REQ-031 start_r>last_r: counter passes 15 to 0 naturally before reaching last_r.
REQ-032 DONE lasts one cycle: cnt_p=cnt_t=0, cnt_ld_n=1, so the counter holds last_r; done=1 in the next cycle; then IDLE.
REQ-033 stop in LOAD or RUN: go to ABORT; stop takes priority over a coincident terminal count, so no wrap, no epoch increment and no done.
REQ-034 ABORT lasts one cycle: cnt_clr_n=0; then IDLE.
REQ-035 stop in IDLE or DONE is ignored.
REQ-036 cfg_valid outside IDLE is ignored; cfg_ready=0 outside IDLE.
REQ-037 epoch retains its value in IDLE until the next transfer.

Reset
REQ-038 When rst is sampled high: state=IDLE; start_r, last_r, epochs_r, epoch = 0; wrap=0, done=0.
REQ-039 While rst is high: cnt_clr_n=0, cnt_ld_n=1, cnt_p=cnt_t=0, cfg_ready=0, busy=0.
REQ-040 Reset overrides every state, including mid-RUN and DONE; no done or wrap pulse follows it.

Configuration
REQ-041 With macro CTRL_PAUSE_EN defined: pause=1 in RUN drives cnt_p=0, cnt_t=1 (counter holds), suppresses terminal-count detection and keeps the state.
REQ-042 Under CTRL_PAUSE_EN: stop still aborts while paused.
REQ-043 Without CTRL_PAUSE_EN: the pause port exists but is ignored.

Verification
REQ-044 rst 2 cycles -> cnt_clr_n=0 during reset; cfg_ready=1 in the first cycle after.
REQ-045 cfg start=3, last=5, epochs=2 -> cnt_q: 3,4,5,3,4,5; wrap pulses at each reload; done one cycle after the second 5; counter holds 5; epoch=2.
REQ-046 cfg start=14, last=1, epochs=1 -> cnt_q: 14,15,0,1; done pulse; no reload load issued.
REQ-047 epochs=0, start=0, last=15 -> runs continuously, epoch wraps 15 to 0; stop coincident with cnt_q=15 -> cnt_clr_n low one cycle, no wrap.
REQ-048 CTRL_PAUSE_EN, pause for 3 cycles at cnt_q=4 -> cnt_q stays 4 for 3 cycles, then resumes to 5.
REQ-049 rst mid-RUN at cnt_q=2 -> IDLE next cycle, done=0, wrap=0, epoch=0.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// Sequencer for an external 74161-style 4-bit counter: loads, runs, reloads at terminal count.
// Optional CTRL_PAUSE_EN: pause input holds the counter in RUN (otherwise pause is ignored).
module counter_seq_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [3:0] cfg_start,
  input  logic [3:0] cfg_last,
  input  logic [3:0] cfg_epochs,
  input  logic       stop,
  input  logic       pause,
  input  logic [3:0] cnt_q,
  output logic       cnt_clr_n,
  output logic       cnt_ld_n,
  output logic       cnt_p,
  output logic       cnt_t,
  output logic [3:0] cnt_d,
  output logic       busy,
  output logic       wrap,
  output logic       done,
  output logic [3:0] epoch
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ABORT} state_t;

  state_t     r_state;
  logic [3:0] r_start, r_last, r_epochs, r_epoch;
  logic       r_wrap, r_done;
  logic       w_pause, w_term, w_final;

`ifdef CTRL_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = pause & 1'b0;
`endif

  assign w_term  = (cnt_q == r_last);
  // the wrap that completes the programmed epochs leaves the counter on last_r
  assign w_final = (r_epochs != 4'd0) && ((r_epoch + 4'd1) == r_epochs);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_start  <= 4'd0;
      r_last   <= 4'd0;
      r_epochs <= 4'd0;
      r_epoch  <= 4'd0;
      r_wrap   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (cfg_valid) begin
          r_start  <= cfg_start;
          r_last   <= cfg_last;
          r_epochs <= cfg_epochs;
          r_epoch  <= 4'd0;
          r_state  <= LOAD;
        end
        LOAD: r_state <= stop ? ABORT : RUN;
        RUN: begin
          if (stop) r_state <= ABORT;
          else if (!w_pause && w_term) begin
            r_epoch <= r_epoch + 4'd1;
            r_wrap  <= 1'b1;
            if (w_final) r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        ABORT:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr_n = 1'b1;
    cnt_ld_n  = 1'b1;
    cnt_p     = 1'b0;
    cnt_t     = 1'b0;
    cnt_d     = 4'd0;
    if (rst) cnt_clr_n = 1'b0;
    else begin
      case (r_state)
        LOAD: begin
          cnt_ld_n = 1'b0;
          cnt_d    = r_start;
        end
        RUN: begin
          // stop freezes the counter for the cycle before ABORT clears it
          if (stop) ;
          else if (w_pause) cnt_t = 1'b1;
          else if (w_term) begin
            if (!w_final) begin
              cnt_ld_n = 1'b0;
              cnt_d    = r_start;
            end
          end else begin
            cnt_p = 1'b1;
            cnt_t = 1'b1;
          end
        end
        ABORT:   cnt_clr_n = 1'b0;
        default: ;
      endcase
    end
  end

  assign cfg_ready = !rst && (r_state == IDLE);
  assign busy      = !rst && ((r_state == LOAD) || (r_state == RUN) || (r_state == DONE));
  assign wrap      = r_wrap;
  assign done      = r_done;
  assign epoch     = r_epoch;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 74161 counter wired to its cnt_* pins.
module tb_counter_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cfg_valid = 1'b0, cfg_ready;
  logic [3:0] cfg_start = 4'd0, cfg_last = 4'd0, cfg_epochs = 4'd0;
  logic       stop = 1'b0, pause = 1'b0;
  logic [3:0] cnt_q = 4'd0;
  logic       cnt_clr_n, cnt_ld_n, cnt_p, cnt_t;
  logic [3:0] cnt_d;
  logic       busy, wrap, done;
  logic [3:0] epoch;
  int         total = 0, bad = 0;

  counter_seq_ctrl dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start(cfg_start), .cfg_last(cfg_last), .cfg_epochs(cfg_epochs),
    .stop(stop), .pause(pause), .cnt_q(cnt_q), .cnt_clr_n(cnt_clr_n),
    .cnt_ld_n(cnt_ld_n), .cnt_p(cnt_p), .cnt_t(cnt_t), .cnt_d(cnt_d),
    .busy(busy), .wrap(wrap), .done(done), .epoch(epoch)
  );

  always #5 clk = ~clk;

  // 74161: asynchronous clear, synchronous load, count when P&T
  always @(posedge clk or negedge cnt_clr_n)
    if (!cnt_clr_n)     cnt_q <= 4'd0;
    else if (!cnt_ld_n) cnt_q <= cnt_d;
    else if (cnt_p && cnt_t) cnt_q <= cnt_q + 4'd1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  // offer a config at a negedge; returns at the negedge of the LOAD cycle
  task automatic do_cfg(input logic [3:0] s, input logic [3:0] l, input logic [3:0] e);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_start = s; cfg_last = l; cfg_epochs = e;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (cnt_clr_n !== 1'b0 || cnt_ld_n !== 1'b1 || cnt_p !== 1'b0 || cnt_t !== 1'b0 ||
          cfg_ready !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_outs: clr_n=%b ld_n=%b p=%b t=%b ready=%b busy=%b required 0 1 0 0 0 0",
                 cnt_clr_n, cnt_ld_n, cnt_p, cnt_t, cfg_ready, busy);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (cfg_ready !== 1'b1 || cnt_clr_n !== 1'b1 || wrap !== 1'b0 || done !== 1'b0 || epoch !== 4'd0 || cnt_q !== 4'd0) begin
      bad++;
      $display("FAIL reset_idle: ready=%b clr_n=%b wrap=%b done=%b epoch=%0d q=%0d required 1 1 0 0 0 0",
               cfg_ready, cnt_clr_n, wrap, done, epoch, cnt_q);
    end
  endtask

  task automatic test_epochs;
    logic [3:0] eq [6];
    logic       ew [6];
    eq = '{4'd3, 4'd4, 4'd5, 4'd3, 4'd4, 4'd5};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_cfg(4'd3, 4'd5, 4'd2);
    total++;
    if (cnt_ld_n !== 1'b0 || cnt_d !== 4'd3 || busy !== 1'b1 || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL ep_load: ld_n=%b d=%0d busy=%b ready=%b required 0 3 1 0", cnt_ld_n, cnt_d, busy, cfg_ready);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (cnt_q !== eq[i] || wrap !== ew[i] || done !== 1'b0 || cfg_ready !== 1'b0) begin
        bad++;
        $display("FAIL ep_run[%0d]: q=%0d wrap=%b done=%b ready=%b required q=%0d wrap=%b done=0 ready=0",
                 i, cnt_q, wrap, done, cfg_ready, eq[i], ew[i]);
      end
      if (i == 1) begin cfg_valid = 1'b1; cfg_start = 4'd9; end
      if (i == 2) cfg_valid = 1'b0;
      if (i == 3) begin
        total++;
        if (epoch !== 4'd1) begin bad++; $display("FAIL ep_mid_epoch: epoch=%0d required 1", epoch); end
      end
    end
    @(negedge clk);
    total++;
    if (cnt_q !== 4'd5 || wrap !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ep_donest: q=%0d wrap=%b done=%b busy=%b required 5 1 0 1", cnt_q, wrap, done, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || cnt_q !== 4'd5 || epoch !== 4'd2 || busy !== 1'b0 || cfg_ready !== 1'b1 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL ep_done: done=%b q=%0d epoch=%0d busy=%b ready=%b wrap=%b required 1 5 2 0 1 0",
               done, cnt_q, epoch, busy, cfg_ready, wrap);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || epoch !== 4'd2 || cnt_q !== 4'd5) begin
      bad++;
      $display("FAIL ep_retain: done=%b epoch=%0d q=%0d required 0 2 5", done, epoch, cnt_q);
    end
  endtask

  task automatic test_natural_wrap;
    logic [3:0] eq [4];
    eq = '{4'd14, 4'd15, 4'd0, 4'd1};
    do_cfg(4'd14, 4'd1, 4'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (cnt_q !== eq[i] || cnt_ld_n !== 1'b1) begin
        bad++;
        $display("FAIL nw_run[%0d]: q=%0d ld_n=%b required q=%0d ld_n=1", i, cnt_q, cnt_ld_n, eq[i]);
      end
    end
    total++;
    if (cnt_p !== 1'b0) begin bad++; $display("FAIL nw_hold: cnt_p=%b required 0", cnt_p); end
    @(negedge clk);
    total++;
    if (cnt_q !== 4'd1 || wrap !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL nw_donest: q=%0d wrap=%b done=%b required 1 1 0", cnt_q, wrap, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || cnt_q !== 4'd1 || epoch !== 4'd1) begin
      bad++;
      $display("FAIL nw_done: done=%b q=%0d epoch=%0d required 1 1 1", done, cnt_q, epoch);
    end
  endtask

  task automatic test_stop;
    int errs = 0;
    do_cfg(4'd0, 4'd15, 4'd0);
    for (int p = 0; p < 17; p++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        if (cnt_q !== 4'(k) || (k == 0 && p > 0 && (wrap !== 1'b1 || epoch !== 4'(p)))) begin
          errs++;
          if (errs < 4)
            $display("FAIL st_run[%0d,%0d]: q=%0d wrap=%b epoch=%0d required q=%0d epoch=%0d",
                     p, k, cnt_q, wrap, epoch, k, p % 16);
        end
        if (p == 16 && k == 15) stop = 1'b1;
      end
    end
    total++;
    if (errs != 0) bad++;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (cnt_clr_n !== 1'b0 || wrap !== 1'b0 || epoch !== 4'd0 || cnt_q !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL st_abort: clr_n=%b wrap=%b epoch=%0d q=%0d busy=%b required 0 0 0 0 0",
               cnt_clr_n, wrap, epoch, cnt_q, busy);
    end
    @(negedge clk);
    total++;
    if (cnt_clr_n !== 1'b1 || cfg_ready !== 1'b1 || done !== 1'b0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL st_idle: clr_n=%b ready=%b done=%b wrap=%b required 1 1 0 0", cnt_clr_n, cfg_ready, done, wrap);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (cfg_ready !== 1'b1 || cnt_clr_n !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL st_idle_stop: ready=%b clr_n=%b busy=%b required 1 1 0", cfg_ready, cnt_clr_n, busy);
    end
  endtask

  task automatic test_pause;
    logic [3:0] eq [4];
`ifdef CTRL_PAUSE_EN
    eq = '{4'd4, 4'd4, 4'd4, 4'd5};
`else
    eq = '{4'd5, 4'd6, 4'd7, 4'd8};
`endif
    do_cfg(4'd2, 4'd9, 4'd1);
    repeat (3) @(negedge clk);
    total++;
    if (cnt_q !== 4'd4) begin bad++; $display("FAIL pa_pre: q=%0d required 4", cnt_q); end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 2) pause = 1'b0;
      total++;
      if (cnt_q !== eq[i]) begin
        bad++;
        $display("FAIL pa_run[%0d]: q=%0d required %0d", i, cnt_q, eq[i]);
      end
    end
    pause = 1'b1; stop = 1'b1;
    @(negedge clk);
    pause = 1'b0; stop = 1'b0;
    total++;
    if (cnt_clr_n !== 1'b0 || wrap !== 1'b0) begin
      bad++;
      $display("FAIL pa_stop: clr_n=%b wrap=%b required 0 0", cnt_clr_n, wrap);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    do_cfg(4'd0, 4'd2, 4'd0);
    repeat (6) @(negedge clk);
    total++;
    if (cnt_q !== 4'd2 || epoch !== 4'd1) begin
      bad++;
      $display("FAIL rm_pre: q=%0d epoch=%0d required 2 1", cnt_q, epoch);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (cnt_clr_n !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
      bad++;
      $display("FAIL rm_inrst: clr_n=%b busy=%b ready=%b required 0 0 0", cnt_clr_n, busy, cfg_ready);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || wrap !== 1'b0 || done !== 1'b0 || epoch !== 4'd0) begin
      bad++;
      $display("FAIL rm_idle: ready=%b busy=%b wrap=%b done=%b epoch=%0d required 1 0 0 0 0",
               cfg_ready, busy, wrap, done, epoch);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || wrap !== 1'b0 || cnt_q !== 4'd0) begin
      bad++;
      $display("FAIL rm_after: done=%b wrap=%b q=%0d required 0 0 0", done, wrap, cnt_q);
    end
  endtask

  initial begin
    test_reset;
    test_epochs;
    test_natural_wrap;
    test_stop;
    test_pause;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
